// File: rtl/memory_pkg.sv
// ============================================================================
// Module   : memory_pkg
// Brief    : Shared constants, types and helpers for the data memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package memory_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int ADDR_WIDTH_DEFAULT = 8;

  // Byte-offset bits dropped to turn a byte address into a word index.
  localparam int WORD_OFFSET_BITS = 2;

  typedef logic [31:0] word_t;

  // Word index of a default-width byte address; the low offset bits are
  // discarded, so misaligned addresses align down to their containing word.
  function automatic logic [ADDR_WIDTH_DEFAULT-1:0] word_index(
    input logic [ADDR_WIDTH_DEFAULT-1:0] addr
  );
    return addr >> WORD_OFFSET_BITS;
  endfunction

endpackage : memory_pkg

`default_nettype wire

// File: rtl/memory.sv
// ============================================================================
// Module   : memory
// Brief    : Byte-addressed, word-organised data memory (64 x 32 bits by
//            default) with synchronous writes and a one-cycle registered read.
//            Reset clears the read register and every stored word.
// Options  : MEMORY_WRITE_BYPASS_EN - when defined, a read and write to the
//            same word in one cycle returns the new write data (write-first);
//            otherwise the old stored word is returned (read-first).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] MemWriteData,
  output logic [DATA_WIDTH-1:0] ReadData
);

  localparam int IDX_WIDTH = ADDR_WIDTH - WORD_OFFSET_BITS;
  localparam int WORDS     = 2 ** IDX_WIDTH;

  logic [DATA_WIDTH-1:0] mem_array [WORDS];
  logic [IDX_WIDTH-1:0]  word_idx;
  logic [DATA_WIDTH-1:0] read_next;

  // Address[1:0] is ignored: misaligned accesses silently hit the word below.
  assign word_idx = Address[ADDR_WIDTH-1:WORD_OFFSET_BITS];

  // Select what the read register loads: the stored word, or the incoming
  // write data when write-first forwarding is built in and a write is present
  // (the write and the read necessarily target the same word here).
  always_comb begin
    read_next = mem_array[word_idx];
`ifdef MEMORY_WRITE_BYPASS_EN
    if (MemWrite) begin
      read_next = MemWriteData;
    end
`else
    read_next = mem_array[word_idx];
`endif
  end

  // Storage array: reset clears every word and blocks any write that cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_array[i] <= '0;
      end
    end else if (MemWrite) begin
      mem_array[word_idx] <= MemWriteData;
    end
  end

  // Read register: loads on a read strobe and otherwise holds its value.
  always_ff @(posedge clock) begin
    if (reset) begin
      ReadData <= '0;
    end else if (MemRead) begin
      ReadData <= read_next;
    end
  end

endmodule : memory

`default_nettype wire

// File: tb/tb_memory.sv
// ============================================================================
// Module   : tb_memory
// Brief    : Directed self-checking bench for the data memory. Expected values
//            are hand-computed; the same-word collision result depends on
//            MEMORY_WRITE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory;

  logic        clock;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [7:0]  Address;
  logic [31:0] MemWriteData;
  logic [31:0] ReadData;

  int n_compared;
  int n_mismatched;

  memory #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Address     (Address),
    .MemWriteData(MemWriteData),
    .ReadData    (ReadData)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present one cycle of inputs, clock it, and settle 1 ns past the edge.
  task automatic cyc(input logic rst, input logic rd, input logic wr,
                     input logic [7:0] addr, input logic [31:0] data);
    reset        = rst;
    MemRead      = rd;
    MemWrite     = wr;
    Address      = addr;
    MemWriteData = data;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] expected);
    n_compared++;
    assert (ReadData === expected)
    else begin
      n_mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, ReadData, expected);
    end
  endtask

  logic [31:0] collide_exp;

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
`ifdef MEMORY_WRITE_BYPASS_EN
    collide_exp = 32'h0000_0077;
`else
    collide_exp = 32'h0000_0005;
`endif
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    Address = 8'h00; MemWriteData = 32'h0;

    // Reset, then read of an untouched word
    cyc(1, 0, 0, 8'h00, 32'h0);
    cyc(1, 0, 0, 8'h00, 32'h0);
    check("reset_readdata", 32'h0);
    cyc(0, 1, 0, 8'h1C, 32'h0);
    check("rd_after_reset_1C", 32'h0);

    // Write sequence; ReadData must hold during writes
    cyc(0, 0, 1, 8'h04, 32'h2);
    cyc(0, 0, 1, 8'h08, 32'h5);
    cyc(0, 0, 1, 8'h0C, 32'h9);
    cyc(0, 0, 1, 8'h18, 32'h7);
    cyc(0, 0, 1, 8'h1C, 32'hA);
    check("hold_during_writes", 32'h0);

    // Back-to-back reads, each visible one edge after presentation
    cyc(0, 1, 0, 8'h18, 32'h0); check("rd_18", 32'h7);
    cyc(0, 1, 0, 8'h04, 32'h0); check("rd_04", 32'h2);
    cyc(0, 1, 0, 8'h1C, 32'h0); check("rd_1C", 32'hA);
    cyc(0, 1, 0, 8'h08, 32'h0); check("rd_08", 32'h5);
    cyc(0, 1, 0, 8'h0C, 32'h0); check("rd_0C", 32'h9);

    // Hold: read 0x08, then idle with a different address for 3 cycles
    cyc(0, 1, 0, 8'h08, 32'h0); check("hold_rd_08", 32'h5);
    cyc(0, 0, 0, 8'h0C, 32'h0); check("hold_idle_1", 32'h5);
    cyc(0, 0, 0, 8'h0C, 32'h0); check("hold_idle_2", 32'h5);
    cyc(0, 0, 0, 8'h0C, 32'h0); check("hold_idle_3", 32'h5);

    // Misaligned accesses align down to the containing word
    cyc(0, 0, 1, 8'h0D, 32'hDEAD_BEEF);
    cyc(0, 1, 0, 8'h0C, 32'h0); check("misalign_rd_0C", 32'hDEAD_BEEF);
    cyc(0, 1, 0, 8'h0F, 32'h0); check("misalign_rd_0F", 32'hDEAD_BEEF);
    cyc(0, 1, 0, 8'h05, 32'h0); check("misalign_rd_05", 32'h2);
    cyc(0, 1, 0, 8'h1A, 32'h0); check("misalign_rd_1A", 32'h7);

    // Same-word read+write collision (word 2 holds 0x5)
    cyc(0, 1, 1, 8'h08, 32'h77); check("collide_rdwr_08", collide_exp);
    cyc(0, 1, 0, 8'h08, 32'h0);  check("collide_after_08", 32'h77);

    // Reset overrides a write and clears all contents
    cyc(1, 0, 1, 8'h04, 32'h33); check("reset_prio_readdata", 32'h0);
    cyc(0, 1, 0, 8'h04, 32'h0);  check("reset_prio_word1", 32'h0);
    cyc(0, 1, 0, 8'h18, 32'h0);  check("reset_clear_18", 32'h0);
    cyc(0, 1, 0, 8'h0C, 32'h0);  check("reset_clear_0C", 32'h0);
    cyc(0, 1, 0, 8'h08, 32'h0);  check("reset_clear_08", 32'h0);

    // Boundary addresses
    cyc(0, 0, 1, 8'h00, 32'h1);
    cyc(0, 0, 1, 8'hFC, 32'hFFFF_FFFF);
    cyc(0, 1, 0, 8'h00, 32'h0); check("boundary_rd_00", 32'h1);
    cyc(0, 1, 0, 8'hFC, 32'h0); check("boundary_rd_FC", 32'hFFFF_FFFF);
    cyc(0, 1, 0, 8'hF8, 32'h0); check("boundary_rd_F8", 32'h0);
    cyc(0, 1, 0, 8'hFF, 32'h0); check("boundary_rd_FF", 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_memory

`default_nettype wire
